bbs32_rand_buffer: RTL and testbench



---
 rtl/bbs32_rand_buffer.sv | 154 +++++++++++++++
 tb/tb_bbs32_rand_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbs32_rand_buffer.sv
// bbs32_rand_buffer: keeps a FIFO of bbs32 result words topped up and
// streams them to a consumer over valid/ready.
`timescale 1ns/1ps
module bbs32_rand_buffer #(
    parameter int DEPTH   = 8,
    parameter int LOW_WM  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    output logic                     gen_start_o,
    input  logic [31:0]              gen_result_i,
    input  logic                     gen_result_valid_i,
    output logic [31:0]              rand_data_o,
    output logic                     rand_valid_o,
    input  logic                     rand_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     timeout_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] LOW_C    = CW'(LOW_WM);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_q, cnt_nxt;
    logic            refill_q, refill;
    logic            discard_q, discard_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            push, pop;

    assign rand_valid_o  = (count_q != '0);
    assign rand_data_o   = mem[rd_ptr];
    assign count_o       = count_q;
    assign busy_o        = (state_q != IDLE);
    assign gen_start_o   = (state_q == REQ);
    assign timeout_err_o = err_q;

    // A flush voids any pop and drops a result arriving in the same cycle.
    assign pop  = rand_valid_o && rand_ready_i && !flush_i;
    assign push = (state_q == WAIT) && gen_result_valid_i
                  && !discard_q && !flush_i;

    // Hysteresis: armed at or below the watermark, held until full.
    assign refill = enable_i && (count_q != FULL_C)
                    && (refill_q || (count_q <= LOW_C));

    // Occupancy after this edge.
    always_comb begin
        cnt_nxt = count_q;
        if (flush_i) begin
            cnt_nxt = '0;
        end else if (push && !pop) begin
            cnt_nxt = count_q + 1'b1;
        end else if (pop && !push) begin
            cnt_nxt = count_q - 1'b1;
        end
    end

    // Request FSM: one outstanding generator request at a time.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        discard_d = discard_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (refill) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (gen_result_valid_i) begin
                    discard_d = 1'b0;
                    if (refill && (cnt_nxt < FULL_C)) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end else if (flush_i) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            refill_q  <= 1'b0;
            discard_q <= 1'b0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= cnt_nxt;
            refill_q  <= refill;
            discard_q <= discard_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Word storage; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem[wr_ptr] <= gen_result_i;
        end
    end

endmodule

// File: tb/tb_bbs32_rand_buffer.sv
// tb_bbs32_rand_buffer: directed checks of bbs32_rand_buffer with a
// behavioural bbs32 responder.
`timescale 1ns/1ps
module tb_bbs32_rand_buffer;

    localparam int DEPTH   = 8;
    localparam int LOW_WM  = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        flush;
    logic        gen_start;
    logic        gen_valid;
    logic [31:0] gen_data;
    logic [31:0] rand_data;
    logic        rand_valid;
    logic        rand_ready;
    logic [3:0]  count;
    logic        busy;
    logic        err;

    logic        mdl_valid = 1'b0;
    logic [31:0] mdl_data  = 32'h0;
    logic        man_valid = 1'b0;
    logic [31:0] man_data  = 32'h0;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;
    int gen_n    = 0;
    int lat      = 5;
    int mode     = 0;
    int pend     = 0;
    bit db_mode  = 1'b0;
    bit db_used  = 1'b0;

    int k;
    int expect_n;
    int n_at;

    assign gen_valid = (mode == 2) ? man_valid : mdl_valid;
    assign gen_data  = (mode == 2) ? man_data  : mdl_data;

    bbs32_rand_buffer #(
        .DEPTH  (DEPTH),
        .LOW_WM (LOW_WM),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .enable_i          (enable),
        .flush_i           (flush),
        .gen_start_o       (gen_start),
        .gen_result_i      (gen_data),
        .gen_result_valid_i(gen_valid),
        .rand_data_o       (rand_data),
        .rand_valid_o      (rand_valid),
        .rand_ready_i      (rand_ready),
        .count_o           (count),
        .busy_o            (busy),
        .timeout_err_o     (err)
    );

    always #5 clk = ~clk;

    // bbs32 stand-in: answers each start 'lat' cycles later (mode 0),
    // never answers (mode 1), or stays quiet for manual drive (mode 2).
    always @(negedge clk) begin
        if (rst) begin
            pend      = 0;
            mdl_valid = 1'b0;
        end else begin
            mdl_valid = 1'b0;
            if (mode == 0 && pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    mdl_valid = 1'b1;
                    if (db_mode && !db_used) begin
                        mdl_data = 32'hDEAD_BEEF;
                        db_used  = 1'b1;
                    end else begin
                        mdl_data = 32'h1000_0000 + 32'(gen_n);
                        gen_n    = gen_n + 1;
                    end
                end
            end
            if (mode == 0 && gen_start) begin
                pend = lat;
            end
        end
    end

    always @(negedge clk) begin
        if (gen_start) begin
            starts = starts + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        flush      = 1'b0;
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rand_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(gen_start), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Fill from empty.
        rst    = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!(count == 4'd8 && !busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("fill_bound", 32'(k < 400), 32'd1);
        chk("fill_starts", 32'(starts), 32'd8);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_valid", 32'(rand_valid), 32'd1);
        chk("fill_head", rand_data, 32'h1000_0000);
        chk("fill_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("fill_no_extra", 32'(starts), 32'd8);

        // Drain to the watermark one word per cycle.
        for (int i = 0; i < 6; i++) begin
            chk("drain_data", rand_data, 32'h1000_0000 + 32'(i));
            chk("drain_nostart", 32'(gen_start), 32'd0);
            rand_ready = 1'b1;
            @(negedge clk);
        end
        rand_ready = 1'b0;
        chk("wm_count", 32'(count), 32'd2);
        chk("wm_nostart", 32'(gen_start), 32'd0);
        @(negedge clk);
        chk("wm_start", 32'(gen_start), 32'd1);
        k = 0;
        while (!(count == 4'd8 && !busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("refill_bound", 32'(k < 400), 32'd1);
        chk("refill_head", rand_data, 32'h1000_0006);
        chk("refill_starts", 32'(starts), 32'd14);

        // Continuous consumption with 1-cycle generator latency.
        lat        = 1;
        rand_ready = 1'b1;
        expect_n   = 6;
        k = 0;
        while (k < 800) begin
            if (expect_n == 32) begin
                break;
            end
            if (rand_valid) begin
                chk("stream_word", rand_data,
                    32'h1000_0000 + 32'(expect_n));
                expect_n++;
            end
            @(negedge clk);
            k++;
        end
        rand_ready = 1'b0;
        enable     = 1'b0;
        chk("stream_bound", 32'(expect_n), 32'd32);
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("stream_idle", 32'(busy), 32'd0);
        chk("stream_count", 32'(count), 32'(gen_n - 32));
        chk("stream_err", 32'(err), 32'd0);

        // Flush while in WAIT drops the in-flight word.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush0_count", 32'(count), 32'd0);
        lat    = 5;
        enable = 1'b1;
        k = 0;
        while (!(count == 4'd5 && busy && !gen_start) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("flush_setup", 32'(k < 200), 32'd1);
        n_at    = gen_n;
        db_mode = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(rand_valid), 32'd0);
        k = 0;
        while (count == 4'd0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("flush_next_cnt", 32'(count), 32'd1);
        chk("flush_next_word", rand_data, 32'h1000_0000 + 32'(n_at));
        chk("flush_db_used", 32'(db_used), 32'd1);

        // Generator timeout.
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        mode   = 1;
        rst    = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!gen_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_start", 32'(gen_start), 32'd1);
        repeat (16) @(negedge clk);
        chk("tmo_not_yet", 32'(err), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("tmo_restart", 32'(gen_start), 32'd1);
        repeat (20) @(negedge clk);
        chk("tmo_sticky", 32'(err), 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("tmo_cleared", 32'(err), 32'd0);

        // Reset mid-WAIT, then a late result.
        mode   = 2;
        rst    = 1'b0;
        enable = 1'b1;
        k = 0;
        while (!gen_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rw_start", 32'(gen_start), 32'd1);
        @(negedge clk);
        chk("rw_wait", 32'(busy), 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        man_valid = 1'b1;
        man_data  = 32'h1234_5678;
        @(negedge clk);
        man_valid = 1'b0;
        repeat (2) begin
            chk("rw_count", 32'(count), 32'd0);
            chk("rw_valid", 32'(rand_valid), 32'd0);
            chk("rw_busy", 32'(busy), 32'd0);
            chk("rw_start0", 32'(gen_start), 32'd0);
            chk("rw_err", 32'(err), 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
